note_sequencer: RTL and testbench

//  Steps a melody through a song ROM at a fixed tempo, so the tone generator

---
 rtl/note_sequencer_if.sv | 29 ++
 rtl/note_sequencer.sv | 139 +++++++++++++
 tb/tb_note_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Player/ROM/tone-generator bundle for the note sequencer.
// The master side is the surrounding system (player control plus song ROM);
// the slave side is the sequencer itself.
interface note_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 4
);
  logic                    start;
  logic                    pause;
  logic                    stop;
  logic [ADDR_W-1:0]       rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic [NOTE_W-1:0]       note;
  logic                    note_valid;
  logic                    beat;
  logic                    busy;
  logic                    done;

  modport master (
    output start, pause, stop, rom_data,
    input  rom_addr, note, note_valid, beat, busy, done
  );

  modport slave (
    input  start, pause, stop, rom_data,
    output rom_addr, note, note_valid, beat, busy, done
  );
endinterface

// File: rtl/note_sequencer.sv
// Note sequencer: walks a song ROM at a fixed tempo and presents one note code
// plus a valid flag to the tone generator. Each ROM word carries a note code
// in the low bits and a duration in beats above it; duration 0 ends the song.
module note_sequencer #(
  parameter int TICK_DIV = 1000,
  parameter int TICK_W   = 10,
  parameter int ADDR_W   = 8,
  parameter int NOTE_W   = 6,
  parameter int DUR_W    = 4,
  parameter bit GAP_EN   = 1'b1,
  parameter bit LOOP     = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  note_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [DUR_W-1:0]    beat_left;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [NOTE_W-1:0]   note_q;

  logic [DUR_W-1:0]    rom_dur;
  logic [NOTE_W-1:0]   rom_note;
  logic                timing;
  logic                running;
  logic                tick_last;
  logic                beat_now;
  logic                last_beat;
  logic                can_advance;

  assign rom_dur     = bus.rom_data[NOTE_W +: DUR_W];
  assign rom_note    = bus.rom_data[NOTE_W-1:0];
  // The prescaler only runs while a note or its gap is being timed and the
  // player is not paused; pausing freezes everything tied to the beat.
  assign timing      = (state == S_PLAY) || (state == S_GAP);
  assign running     = timing && !bus.pause;
  assign tick_last   = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign beat_now    = running && tick_last;
  assign last_beat   = (beat_left == DUR_W'(1));
  // At the top address a non-looping song has nowhere left to go.
  assign can_advance = (rom_addr_q != '1) || LOOP;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours.
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; stop overrides every other request.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nxt
    // unassigned and infers a latch.
    state_nxt = state;
    if (bus.stop) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.start) state_nxt = S_FETCH;
        S_FETCH: state_nxt = S_WAIT;
        S_WAIT: begin
          if (rom_dur != '0)                  state_nxt = S_PLAY;
          else if (LOOP && rom_addr_q != '0)  state_nxt = S_FETCH;
          else                                state_nxt = S_DONE;
        end
        S_PLAY: begin
          if (beat_now && last_beat) begin
            if (GAP_EN)           state_nxt = S_GAP;
            else if (can_advance) state_nxt = S_FETCH;
            else                  state_nxt = S_DONE;
          end
        end
        S_GAP: begin
          if (beat_now) state_nxt = can_advance ? S_FETCH : S_DONE;
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: prescaler, beats remaining, ROM address and the current note.
  always_ff @(posedge clk) begin
    if (!reset_n || bus.stop) begin
      tick_cnt   <= '0;
      beat_left  <= '0;
      rom_addr_q <= '0;
      note_q     <= '0;
    end else begin
      if (running)     tick_cnt <= tick_last ? '0 : tick_cnt + TICK_W'(1);
      else if (!timing) tick_cnt <= '0;

      case (state)
        S_IDLE: if (bus.start) rom_addr_q <= '0;
        S_WAIT: begin
          if (rom_dur != '0) begin
            beat_left <= rom_dur;
            note_q    <= rom_note;
          end else if (LOOP && rom_addr_q != '0) begin
            rom_addr_q <= '0;
          end
        end
        S_PLAY: begin
          if (beat_now) begin
            beat_left <= beat_left - DUR_W'(1);
            if (last_beat && !GAP_EN && can_advance)
              rom_addr_q <= rom_addr_q + ADDR_W'(1);
          end
        end
        S_GAP: if (beat_now && can_advance) rom_addr_q <= rom_addr_q + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  // Output decode; note_valid drops immediately while paused.
  always_comb begin
    bus.rom_addr   = rom_addr_q;
    bus.note       = note_q;
    bus.note_valid = (state == S_PLAY) && !bus.pause;
    bus.beat       = beat_now;
    bus.busy       = (state != S_IDLE);
    bus.done       = (state == S_DONE);
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, ADDR_W=3, NOTE_W=6,
// DUR_W=4. Three instances cover the parameter variants:
//   a: GAP_EN=1 LOOP=0   b: GAP_EN=0 LOOP=0   c: GAP_EN=0 LOOP=1
// Inputs change just after a falling edge; outputs are checked 1 time unit
// later, well clear of the rising edge. Sample index k counts falling edges
// after the one where start was raised.
module tb_note_sequencer;
  localparam int TICK_DIV = 4;
  localparam int TICK_W   = 2;
  localparam int ADDR_W   = 3;
  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 4;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic [NOTE_W+DUR_W-1:0] rom_ab [8];
  logic [NOTE_W+DUR_W-1:0] rom_c  [8];

  note_sequencer_if #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus_a ();
  note_sequencer_if #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus_b ();
  note_sequencer_if #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus_c ();

  note_sequencer #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W), .ADDR_W(ADDR_W), .NOTE_W(NOTE_W),
                   .DUR_W(DUR_W), .GAP_EN(1'b1), .LOOP(1'b0))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  note_sequencer #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W), .ADDR_W(ADDR_W), .NOTE_W(NOTE_W),
                   .DUR_W(DUR_W), .GAP_EN(1'b0), .LOOP(1'b0))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));
  note_sequencer #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W), .ADDR_W(ADDR_W), .NOTE_W(NOTE_W),
                   .DUR_W(DUR_W), .GAP_EN(1'b0), .LOOP(1'b1))
    dut_c (.clk(clk), .reset_n(reset_n), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song ROMs with one cycle of read latency.
  always @(posedge clk) begin
    bus_a.rom_data <= rom_ab[bus_a.rom_addr];
    bus_b.rom_data <= rom_ab[bus_b.rom_addr];
    bus_c.rom_data <= rom_c[bus_c.rom_addr];
  end

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s k=%0d observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus_a.start = 1'b0; bus_a.pause = 1'b0; bus_a.stop = 1'b0;
    bus_b.start = 1'b0; bus_b.pause = 1'b0; bus_b.stop = 1'b0;
    bus_c.start = 1'b0; bus_c.pause = 1'b0; bus_c.stop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rom_ab[i] = '0;
      rom_c[i]  = {4'd1, 6'(10 + i)};
    end
    rom_ab[0] = {4'd2, 6'd5};
    rom_ab[1] = {4'd1, 6'd9};
    rom_ab[2] = {4'd0, 6'd0};

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy_a", 0, bus_a.busy, 0);
    check("rst_valid_a", 0, bus_a.note_valid, 0);
    check("rst_addr_a", 0, bus_a.rom_addr, 0);
    check("rst_note_a", 0, bus_a.note, 0);
    check("rst_beat_a", 0, bus_a.beat, 0);
    check("rst_done_a", 0, bus_a.done, 0);
    check("rst_busy_b", 0, bus_b.busy, 0);
    check("rst_busy_c", 0, bus_c.busy, 0);
    reset_n = 1'b1;

    // Song {d2 n5, d1 n9, end}: a with gap beats, b without.
    // b also receives a start pulse while playing, which must be ignored.
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_b.start = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      bus_b.start = (k == 4);
      #1;
      check("t1_valid", k, bus_a.note_valid, (k >= 3 && k <= 10) || (k >= 17 && k <= 20));
      check("t1_beat", k, bus_a.beat, k == 6 || k == 10 || k == 14 || k == 20 || k == 24);
      check("t1_done", k, bus_a.done, k == 27);
      check("t1_busy", k, bus_a.busy, k <= 27);
      if (k == 3)  check("t1_note5", k, bus_a.note, 5);
      if (k == 17) check("t1_note9", k, bus_a.note, 9);
      if (k == 15) check("t1_addr1", k, bus_a.rom_addr, 1);
      if (k == 25) check("t1_addr2", k, bus_a.rom_addr, 2);
      check("t2_valid", k, bus_b.note_valid, (k >= 3 && k <= 10) || (k >= 13 && k <= 16));
      check("t2_beat", k, bus_b.beat, k == 6 || k == 10 || k == 16);
      check("t2_done", k, bus_b.done, k == 19);
      check("t2_busy", k, bus_b.busy, k <= 19);
      if (k == 5)  check("t2_note5", k, bus_b.note, 5);
      if (k == 11) check("t2_addr1", k, bus_b.rom_addr, 1);
      if (k == 13) check("t2_note9", k, bus_b.note, 9);
    end
    bus_b.start = 1'b0;

    // Pause for 10 cycles from the third cycle of note 5: everything after
    // that point shifts by exactly 10 samples.
    @(negedge clk);
    bus_a.start = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      bus_a.pause = (k >= 5 && k <= 14);
      #1;
      check("t3_valid", k, bus_a.note_valid,
            (k >= 3 && k <= 4) || (k >= 15 && k <= 20) || (k >= 27 && k <= 30));
      check("t3_beat", k, bus_a.beat, k == 16 || k == 20 || k == 24 || k == 30 || k == 34);
      check("t3_done", k, bus_a.done, k == 37);
      check("t3_busy", k, bus_a.busy, k <= 37);
      if (k == 15) check("t3_note5", k, bus_a.note, 5);
      if (k == 27) check("t3_note9", k, bus_a.note, 9);
    end
    bus_a.pause = 1'b0;

    // Stop mid-note, then start together with stop while idle.
    @(negedge clk);
    bus_a.start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus_a.start = (k == 10);
      bus_a.stop  = (k == 5) || (k == 10);
      #1;
      check("t4_busy", k, bus_a.busy, k <= 5);
      check("t4_valid", k, bus_a.note_valid, k >= 3 && k <= 5);
      check("t4_done", k, bus_a.done, 0);
      if (k >= 6) begin
        check("t4_addr", k, bus_a.rom_addr, 0);
        check("t4_note", k, bus_a.note, 0);
      end
    end
    bus_a.start = 1'b0;
    bus_a.stop  = 1'b0;

    // Looping song of eight one-beat notes: six samples per note
    // (FETCH, WAIT, four PLAY); address 7 wraps back to 0 and note 10.
    @(negedge clk);
    bus_c.start = 1'b1;
    for (int k = 1; k <= 54; k++) begin
      int p;
      int ph;
      @(negedge clk);
      bus_c.start = 1'b0;
      #1;
      p  = (k - 1) / 6;
      ph = (k - 1) % 6;
      check("t5_valid", k, bus_c.note_valid, ph >= 2);
      check("t5_beat", k, bus_c.beat, ph == 5);
      check("t5_addr", k, bus_c.rom_addr, p % 8);
      check("t5_busy", k, bus_c.busy, 1);
      if (ph >= 2) check("t5_note", k, bus_c.note, 10 + (p % 8));
    end
    @(negedge clk);
    bus_c.stop = 1'b1;
    @(negedge clk);
    bus_c.stop = 1'b0;
    #1;
    check("t5_stop_busy", 0, bus_c.busy, 0);

    // End marker at address 0 with LOOP=1: straight to DONE, no livelock.
    rom_c[0] = {4'd0, 6'd0};
    @(negedge clk);
    bus_c.start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus_c.start = 1'b0;
      #1;
      check("t5e_busy", k, bus_c.busy, k <= 3);
      check("t5e_done", k, bus_c.done, k == 3);
      check("t5e_valid", k, bus_c.note_valid, 0);
      check("t5e_addr", k, bus_c.rom_addr, 0);
    end

    // Reset mid-note; start is ignored while reset is held, honoured after.
    @(negedge clk);
    bus_b.start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      reset_n     = !(k >= 5 && k <= 7);
      bus_b.start = (k == 6) || (k == 7) || (k == 9);
      #1;
      check("t6_busy", k, bus_b.busy, (k <= 5) || (k >= 10));
      check("t6_valid", k, bus_b.note_valid, k >= 3 && k <= 5);
      if (k >= 6 && k <= 9) begin
        check("t6_addr", k, bus_b.rom_addr, 0);
        check("t6_note", k, bus_b.note, 0);
        check("t6_beat", k, bus_b.beat, 0);
        check("t6_done", k, bus_b.done, 0);
      end
    end
    bus_b.start = 1'b0;
    reset_n = 1'b1;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
